data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits.
REQ-002 Parameter ADDR_W, default 10: word-address width; the array holds 2^ADDR_W words.
REQ-003 Parameter WAIT_STATES, default 2, legal range 0..15: cycles spent in WAIT per access.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 MemEn  input  1  access request from the control unit; held high until mem_ready is seen.
REQ-007 MemWen  input  1  1 = write, 0 = read; sampled with MemEn.
REQ-008 addr  input  32  byte address; sampled with MemEn.
REQ-009 wdata  input  DATA_W  write data; sampled with MemEn.
REQ-010 mem_ready  output  1  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  read data, valid while mem_ready is high and held until the next completion.
REQ-012 mem_err  output  1  access rejected; valid while mem_ready is high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 access_cnt  output  16  count of completed non-error accesses, saturating at 16'hFFFF.

Function
REQ-015 States: IDLE, WAIT, ACCESS, DONE; reset state is IDLE.
REQ-016 IDLE with MemEn=1: latch MemWen, addr and wdata, clear the wait counter, and go to WAIT (or to ACCESS if WAIT_STATES=0).
REQ-017 Legality check on latched addr: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 is illegal; an illegal request goes from IDLE directly to DONE with mem_err=1.
REQ-018 WAIT: increment the counter each cycle; go to ACCESS when counter = WAIT_STATES-1.
REQ-019 WAIT with MemEn=0 (abort): return to IDLE with no write, no mem_ready pulse and access_cnt unchanged.
REQ-020 ACCESS: a write commits wdata to word addr[ADDR_W+1:2] at the end of the cycle; a read captures the word into the rdata register; go to DONE.
REQ-021 MemEn is ignored in ACCESS and DONE, so an access is not abortable once in ACCESS.
REQ-022 DONE: mem_ready=1 for exactly one cycle, then IDLE.
REQ-023 On a legal completion: mem_err=0 and access_cnt increments in the DONE cycle.
REQ-024 On an illegal completion: rdata=0, no array write, access_cnt unchanged.
REQ-025 Latency: MemEn sampled in IDLE at cycle t gives mem_ready in cycle t+WAIT_STATES+2 for a legal access, and t+1 for an illegal one.
REQ-026 Back-to-back: MemEn=1 in the IDLE cycle right after DONE starts a new access; the initiator deasserts MemEn in that cycle if it wants no further access.
REQ-027 A write followed by a read of the same address returns the new data.
REQ-028 rdata is registered and unchanged by writes, aborts and illegal requests except where REQ-024 applies.

Reset
REQ-029 reset=0 sampled at a rising edge: state=IDLE, mem_ready=0, mem_err=0, busy=0, rdata=0, access_cnt=0, latched request cleared.
REQ-030 Reset during WAIT or ACCESS discards the access; no array write may commit in a cycle where reset=0.
REQ-031 Array contents are not reset.

Structure
REQ-032 Shared package cpu_pkg holds the responder state enum and the default DATA_W, ADDR_W and WAIT_STATES constants.
REQ-033 Storage is a sub-module mem_array: single-port synchronous RAM with clk, we, addr, din and registered dout.
REQ-034 The FSM, wait counter, legality check and access counter are in data_mem_responder.

Verification
REQ-035 Write then read: write 0xDEADBEEF to 0x10, then read 0x10 -> each mem_ready arrives 4 cycles after MemEn sampled, rdata=0xDEADBEEF, mem_err=0, access_cnt=2.
REQ-036 Misaligned and out-of-range: read 0x13, then read 0x1000 -> mem_ready arrives 1 cycle after each, mem_err=1, rdata=0, access_cnt unchanged.
REQ-037 Abort: write 0x55 to 0x20 with MemEn dropped in the first WAIT cycle -> no mem_ready, and a later read of 0x20 returns its prior value.
REQ-038 Reset mid-access: reset=0 in the ACCESS cycle of a write to 0x30 -> outputs match REQ-029 and word 0x30 is unchanged.
REQ-039 Back-to-back with WAIT_STATES=0: three reads with MemEn held continuously -> mem_ready every 3 cycles and access_cnt=3.
REQ-040 Saturation: preload access_cnt near 0xFFFF and complete 3 legal accesses -> access_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the data memory responder: default
//                widths, default wait-state count, the responder state
//                encoding and the address legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_DATA_W      = 32;
    localparam int c_ADDR_W      = 10;
    localparam int c_WAIT_STATES = 2;

    // Responder state encoding
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] resp_state_t;

    localparam resp_state_t c_ST_IDLE   = 2'd0;
    localparam resp_state_t c_ST_WAIT   = 2'd1;
    localparam resp_state_t c_ST_ACCESS = 2'd2;
    localparam resp_state_t c_ST_DONE   = 2'd3;

    // A byte address is legal when word aligned and inside the 2^aw word array
    function automatic logic addr_is_legal(input logic [31:0] a, input int unsigned aw);
        logic [31:0] w_hi;
        w_hi = a >> (aw + 32'd2);
        return (a[1:0] == 2'b00) && (w_hi == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Request/response bundle between the control unit (master)
//                and the data memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
);

    logic              MemEn;
    logic              MemWen;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] rdata;
    logic              mem_err;
    logic              busy;
    logic [15:0]       access_cnt;

    modport master (
        output MemEn, MemWen, addr, wdata,
        input  mem_ready, rdata, mem_err, busy, access_cnt
    );

    modport slave (
        input  MemEn, MemWen, addr, wdata,
        output mem_ready, rdata, mem_err, busy, access_cnt
    );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port synchronous RAM, read-first, registered output.
//                Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import cpu_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_dout;

    // Write on we, always register the addressed word onto dout
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_dout <= r_mem[addr];
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Wait-state data memory responder. Accepts one access at a
//                time from the control unit, inserts WAIT_STATES cycles,
//                performs the read/write and pulses mem_ready for one cycle.
//                Misaligned or out-of-range requests complete immediately
//                with mem_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int          DATA_W         = c_DATA_W,
    parameter int          ADDR_W         = c_ADDR_W,
    parameter int          WAIT_STATES    = c_WAIT_STATES,
    // Reset value of the completion counter; 0 in normal use
    parameter logic [15:0] ACCESS_CNT_RST = 16'h0000
) (
    input wire logic            clk,
    input wire logic            reset,
    data_mem_responder_if.slave bus
);

    localparam int         c_WAIT_LAST   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] c_WAIT_LAST_V = 4'(c_WAIT_LAST);

    resp_state_t       r_state;
    logic              r_wen;
    logic [ADDR_W-1:0] r_word;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wait_cnt;
    logic              r_mem_ready;
    logic              r_mem_err;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_access_cnt;

    logic              w_legal;
    logic [ADDR_W-1:0] w_in_word;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_dout;

    assign w_legal   = addr_is_legal(bus.addr, ADDR_W);
    assign w_in_word = bus.addr[ADDR_W+1:2];

    // In IDLE the RAM is pointed at the incoming address so the read word is
    // already on dout by the ACCESS cycle; afterwards it follows the latch.
    assign w_mem_addr = (r_state == c_ST_IDLE) ? w_in_word : r_word;

    // Writes commit only at the end of ACCESS and never while reset is held
    assign w_mem_we = (r_state == c_ST_ACCESS) && r_wen && reset;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk  (clk),
        .we   (w_mem_we),
        .addr (w_mem_addr),
        .din  (r_wdata),
        .dout (w_mem_dout)
    );

    // Responder FSM with registered handshake outputs and completion counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_wen        <= 1'b0;
            r_word       <= '0;
            r_wdata      <= '0;
            r_wait_cnt   <= '0;
            r_mem_ready  <= 1'b0;
            r_mem_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_rdata      <= '0;
            r_access_cnt <= ACCESS_CNT_RST;
        end else begin
            r_mem_ready <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_mem_err <= 1'b0;
                    if (bus.MemEn) begin
                        r_wen      <= bus.MemWen;
                        r_word     <= w_in_word;
                        r_wdata    <= bus.wdata;
                        r_wait_cnt <= '0;
                        r_busy     <= 1'b1;
                        if (!w_legal) begin
                            r_state     <= c_ST_DONE;
                            r_mem_ready <= 1'b1;
                            r_mem_err   <= 1'b1;
                            r_rdata     <= '0;
                        end else if (WAIT_STATES == 0) begin
                            r_state <= c_ST_ACCESS;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                    if (!bus.MemEn) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wait_cnt == c_WAIT_LAST_V) begin
                        r_state <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    if (!r_wen) begin
                        r_rdata <= w_mem_dout;
                    end
                    r_mem_err   <= 1'b0;
                    r_mem_ready <= 1'b1;
                    if (r_access_cnt != 16'hFFFF) begin
                        r_access_cnt <= r_access_cnt + 16'd1;
                    end
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_state   <= c_ST_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_err <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_ready  = r_mem_ready;
    assign bus.rdata      = r_rdata;
    assign bus.mem_err    = r_mem_err;
    assign bus.busy       = r_busy;
    assign bus.access_cnt = r_access_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder.
//                dut_a: WAIT_STATES=2; dut_b: WAIT_STATES=0;
//                dut_c: WAIT_STATES=0 with counter preloaded to 0xFFFD.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(32)) if_a ();
    data_mem_responder_if #(.DATA_W(32)) if_b ();
    data_mem_responder_if #(.DATA_W(32)) if_c ();

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(10), .WAIT_STATES(2), .ACCESS_CNT_RST(16'h0000)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(10), .WAIT_STATES(0), .ACCESS_CNT_RST(16'h0000)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(10), .WAIT_STATES(0), .ACCESS_CNT_RST(16'hFFFD)
    ) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on dut_a from IDLE; lat counts cycles from the sampling
    // cycle to the mem_ready cycle (capped at 20).
    task automatic acc_a(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic err,
                         output logic bsy);
        if_a.MemEn  = 1'b1;
        if_a.MemWen = wen;
        if_a.addr   = a;
        if_a.wdata  = wd;
        tick();
        lat = 1;
        bsy = if_a.busy;
        while (!if_a.mem_ready && lat < 20) begin
            tick();
            lat++;
        end
        rd  = if_a.rdata;
        err = if_a.mem_err;
        if_a.MemEn = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached, expected run to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        logic        bsy;
        logic        seen;
        logic [8:0]  mask;

        if_a.MemEn = 1'b0; if_a.MemWen = 1'b0; if_a.addr = 32'h0; if_a.wdata = 32'h0;
        if_b.MemEn = 1'b0; if_b.MemWen = 1'b0; if_b.addr = 32'h0; if_b.wdata = 32'h0;
        if_c.MemEn = 1'b0; if_c.MemWen = 1'b0; if_c.addr = 32'h0; if_c.wdata = 32'h0;

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        check_vec("rst_mem_ready", 32'(if_a.mem_ready), 32'd0);
        check_vec("rst_mem_err",   32'(if_a.mem_err),   32'd0);
        check_vec("rst_busy",      32'(if_a.busy),      32'd0);
        check_vec("rst_rdata",     if_a.rdata,          32'h0);
        check_vec("rst_cnt",       32'(if_a.access_cnt), 32'h0);
        check_vec("rst_cnt_c",     32'(if_c.access_cnt), 32'hFFFD);
        reset = 1'b1;
        tick();

        // Write then read 0x10
        acc_a(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, err, bsy);
        check_vec("wr10_lat",  32'(lat), 32'd4);
        check_vec("wr10_err",  32'(err), 32'd0);
        check_vec("wr10_busy", 32'(bsy), 32'd1);
        acc_a(1'b0, 32'h10, 32'h0, lat, rd, err, bsy);
        check_vec("rd10_lat",  32'(lat), 32'd4);
        check_vec("rd10_data", rd,       32'hDEADBEEF);
        check_vec("rd10_err",  32'(err), 32'd0);
        check_vec("rd10_cnt",  32'(if_a.access_cnt), 32'd2);

        // Misaligned and out-of-range
        acc_a(1'b0, 32'h13, 32'h0, lat, rd, err, bsy);
        check_vec("mis_lat",   32'(lat), 32'd1);
        check_vec("mis_err",   32'(err), 32'd1);
        check_vec("mis_rdata", rd,       32'h0);
        check_vec("mis_busy",  32'(bsy), 32'd1);
        acc_a(1'b0, 32'h1000, 32'h0, lat, rd, err, bsy);
        check_vec("oor_lat",   32'(lat), 32'd1);
        check_vec("oor_err",   32'(err), 32'd1);
        check_vec("oor_rdata", rd,       32'h0);
        check_vec("oor_cnt",   32'(if_a.access_cnt), 32'd2);
        check_vec("oor_err_clr", 32'(if_a.mem_err), 32'd0);

        // Abort in the first WAIT cycle
        acc_a(1'b1, 32'h20, 32'h12345678, lat, rd, err, bsy);
        check_vec("wr20_lat", 32'(lat), 32'd4);
        if_a.MemEn  = 1'b1;
        if_a.MemWen = 1'b1;
        if_a.addr   = 32'h20;
        if_a.wdata  = 32'h55;
        tick();
        check_vec("abort_busy_wait", 32'(if_a.busy), 32'd1);
        if_a.MemEn = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (if_a.mem_ready) seen = 1'b1;
        end
        check_vec("abort_no_ready", 32'(seen), 32'd0);
        check_vec("abort_busy_idle", 32'(if_a.busy), 32'd0);
        check_vec("abort_cnt", 32'(if_a.access_cnt), 32'd3);
        acc_a(1'b0, 32'h20, 32'h0, lat, rd, err, bsy);
        check_vec("abort_rd20", rd, 32'h12345678);
        check_vec("abort_rd_cnt", 32'(if_a.access_cnt), 32'd4);

        // Reset during the ACCESS cycle of a write to 0x30
        acc_a(1'b1, 32'h30, 32'hAAAA0000, lat, rd, err, bsy);
        check_vec("wr30_cnt", 32'(if_a.access_cnt), 32'd5);
        if_a.MemEn  = 1'b1;
        if_a.MemWen = 1'b1;
        if_a.addr   = 32'h30;
        if_a.wdata  = 32'hBBBB1111;
        repeat (3) tick();
        check_vec("midrst_busy_acc", 32'(if_a.busy), 32'd1);
        reset      = 1'b0;
        if_a.MemEn = 1'b0;
        tick();
        check_vec("midrst_mem_ready", 32'(if_a.mem_ready), 32'd0);
        check_vec("midrst_mem_err",   32'(if_a.mem_err),   32'd0);
        check_vec("midrst_busy",      32'(if_a.busy),      32'd0);
        check_vec("midrst_rdata",     if_a.rdata,          32'h0);
        check_vec("midrst_cnt",       32'(if_a.access_cnt), 32'd0);
        reset = 1'b1;
        tick();
        acc_a(1'b0, 32'h30, 32'h0, lat, rd, err, bsy);
        check_vec("midrst_rd30", rd, 32'hAAAA0000);
        check_vec("midrst_rd_cnt", 32'(if_a.access_cnt), 32'd1);

        // Back-to-back, WAIT_STATES=0, MemEn held for three accesses
        if_b.MemEn  = 1'b1;
        if_b.MemWen = 1'b0;
        if_b.addr   = 32'h10;
        mask = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            mask[k-1] = if_b.mem_ready;
            if (k == 9) if_b.MemEn = 1'b0;
        end
        repeat (2) tick();
        check_vec("b2b_ready_mask", 32'(mask), 32'h092);
        check_vec("b2b_cnt", 32'(if_b.access_cnt), 32'd3);
        check_vec("b2b_idle", 32'(if_b.busy), 32'd0);

        // Counter saturation from 0xFFFD
        if_c.MemEn  = 1'b1;
        if_c.MemWen = 1'b1;
        if_c.addr   = 32'h40;
        if_c.wdata  = 32'hCAFEF00D;
        mask = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            mask[k-1] = if_c.mem_ready;
            if (k == 3) check_vec("sat_cnt_1", 32'(if_c.access_cnt), 32'hFFFE);
            if (k == 6) check_vec("sat_cnt_2", 32'(if_c.access_cnt), 32'hFFFF);
            if (k == 9) if_c.MemEn = 1'b0;
        end
        repeat (2) tick();
        check_vec("sat_ready_mask", 32'(mask), 32'h092);
        check_vec("sat_cnt_3", 32'(if_c.access_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
